// File: rtl/core_pkg.sv
// Shared types for the execute/memory stage: FSM states, default widths and the
// latched memory-request payload.
package core_pkg;

    localparam int unsigned MEM_ADDR_W = 25;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned RD_W       = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [RD_W-1:0]       rd;
        logic                  rwe;
        logic                  fwe;
    } mem_req_t;

endpackage

// File: rtl/mem_access.sv
// Execute/memory stage: forwards ALU results, runs data-memory transactions and
// drives the register-file writeback registers.
module mem_access
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [4:0]        dec_rd,
    input  logic              dec_mre,
    input  logic              dec_mwe,
    input  logic              dec_rwe,
    input  logic              dec_fwe,
    input  logic [ADDR_W-1:0] dec_daddr,
    output logic [DATA_W-1:0] alu_fw,
    output logic [4:0]        alu_rd,
    output logic              alu_rwe,
    output logic              alu_fwe,
    output logic [DATA_W-1:0] wb_res,
    output logic [DATA_W-1:0] wb_memdata,
    output logic              wb_rwe,
    output logic              wb_fwe,
    output logic              wb_mre,
    output logic [4:0]        wb_rd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    mem_state_t        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] wb_res_q, wb_res_d;
    logic [DATA_W-1:0] wb_memdata_q, wb_memdata_d;
    logic              wb_rwe_q, wb_rwe_d;
    logic              wb_fwe_q, wb_fwe_d;
    logic              wb_mre_q, wb_mre_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              req_issue;

    // Loads never forward; their data arrives later through the wb path.
    assign alu_fw  = alu_res;
    assign alu_rd  = dec_rd;
    assign alu_rwe = dec_rwe & ~dec_mre;
    assign alu_fwe = dec_fwe & ~dec_mre;

    assign mem_req    = req_issue & ~rst;
    assign wb_res     = wb_res_q;
    assign wb_memdata = wb_memdata_q;
    assign wb_rwe     = wb_rwe_q;
    assign wb_fwe     = wb_fwe_q;
    assign wb_mre     = wb_mre_q;
    assign wb_rd      = wb_rd_q;
    assign stall_cnt  = stall_cnt_q;

    // Next-state, request drive and writeback selection.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        req_issue    = 1'b0;
        stall        = 1'b0;
        mem_we       = req_q.we;
        mem_addr     = ADDR_W'(req_q.addr);
        mem_wdata    = DATA_W'(req_q.wdata);
        wb_res_d     = wb_res_q;
        wb_memdata_d = wb_memdata_q;
        wb_rwe_d     = wb_rwe_q;
        wb_fwe_d     = wb_fwe_q;
        wb_mre_d     = wb_mre_q;
        wb_rd_d      = wb_rd_q;

        case (state_q)
            IDLE: begin
                if (dec_mre || dec_mwe) begin
                    req_issue = 1'b1;
                    mem_we    = dec_mwe;
                    mem_addr  = dec_daddr;
                    mem_wdata = op2;
                    req_d     = '{we:    dec_mwe,
                                  addr:  MEM_ADDR_W'(dec_daddr),
                                  wdata: MEM_DATA_W'(op2),
                                  rd:    dec_rd,
                                  rwe:   dec_rwe,
                                  fwe:   dec_fwe};
                    // A simultaneous load+store flag is resolved as a store.
                    if (dec_mwe) begin
                        if (mem_ready) begin
                            wb_res_d = alu_res;
                            wb_rwe_d = 1'b0;
                            wb_fwe_d = 1'b0;
                            wb_mre_d = 1'b0;
                            wb_rd_d  = dec_rd;
                        end else begin
                            stall   = 1'b1;
                            state_d = REQ;
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = mem_ready ? RESP : REQ;
                    end
                end else begin
                    wb_res_d = alu_res;
                    wb_rwe_d = dec_rwe;
                    wb_fwe_d = dec_fwe;
                    wb_mre_d = 1'b0;
                    wb_rd_d  = dec_rd;
                end
            end
            REQ: begin
                req_issue = 1'b1;
                if (mem_ready && req_q.we) begin
                    wb_res_d = alu_res;
                    wb_rwe_d = 1'b0;
                    wb_fwe_d = 1'b0;
                    wb_mre_d = 1'b0;
                    wb_rd_d  = req_q.rd;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                    if (mem_ready) state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    wb_memdata_d = mem_rdata;
                    wb_mre_d     = 1'b1;
                    wb_rwe_d     = req_q.rwe;
                    wb_fwe_d     = req_q.fwe;
                    wb_rd_d      = req_q.rd;
                    wb_res_d     = alu_res;
                    state_d      = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_cnt_d = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    // State, request and writeback registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            wb_res_q     <= '0;
            wb_memdata_q <= '0;
            wb_rwe_q     <= 1'b0;
            wb_fwe_q     <= 1'b0;
            wb_mre_q     <= 1'b0;
            wb_rd_q      <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            wb_res_q     <= wb_res_d;
            wb_memdata_q <= wb_memdata_d;
            wb_rwe_q     <= wb_rwe_d;
            wb_fwe_q     <= wb_fwe_d;
            wb_mre_q     <= wb_mre_d;
            wb_rd_q      <= wb_rd_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule
